pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It drives the enable and synchronous-flush inputs of the F, F/D, D/E, E/M and M/W pipeline registers. It resolves load-use hazards, branch mispredicts and data-memory wait states, and can drain the pipeline to a clean halt. It also freezes the pipeline permanently if a memory access exceeds a bounded wait.

---
 rtl/pipeline_hazard_controller.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage pipeline; optional perf counters under HAZARD_PERF_CNT_EN
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        mispredict_E,
  input  logic        mem_req_M,
  input  logic        mem_ready,
  input  logic        halt_req,
  output logic        en_F,
  output logic        en_D,
  output logic        en_E,
  output logic        en_M,
  output logic        en_W,
  output logic        flush_D,
  output logic        flush_E,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED, ERROR} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0] drain_q, drain_d;
  logic [4:0] en;
  logic [1:0] fl;
  logic freeze, load_use, active, adv;
  assign freeze = mem_req_M & ~mem_ready;
  assign load_use = RegWriteE & (ResultSrcE == 2'b01) & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign active = (state_q == RUN) | (state_q == DRAIN);
  assign {en_F, en_D, en_E, en_M, en_W} = en;
  assign {flush_D, flush_E} = fl;
  assign halted = state_q == HALTED;
  assign mem_timeout = state_q == ERROR;
  // hazard priority resolution, drain sequencing and memory-wait watchdog
  always_comb begin
    en = 5'b0;
    fl = 2'b0;
    adv = 1'b0;
    state_d = state_q;
    wait_d = '0;
    drain_d = drain_q;
    if (active) begin
      if (freeze) begin
        wait_d = wait_q + 1'b1;
        state_d = (wait_q == WAIT_LAST) ? ERROR : state_q;
      end else if (mispredict_E) begin
        en = 5'b11111;
        fl = 2'b11;
        adv = 1'b1;
      end else if (load_use) begin
        en = 5'b00111;
        fl = 2'b01;
      end else begin
        en = {state_q == RUN, 4'b1111};
        fl = {state_q == DRAIN, 1'b0};
        adv = 1'b1;
      end
      if (state_q == RUN && halt_req && !freeze) begin
        state_d = DRAIN;
        drain_d = 2'd0;
      end
      if (state_q == DRAIN && adv) begin
        drain_d = drain_q + 2'd1;
        state_d = (drain_q == 2'd3) ? HALTED : state_q;
      end
    end else if (state_q == HALTED) begin
      en = 5'b00111;
      state_d = halt_req ? HALTED : RUN;
    end
    if (!rst) begin
      en = 5'b0;
      fl = 2'b0;
    end
  end
  // sequencer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q <= '0;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      drain_q <= drain_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  // stalls are active cycles with F/D held; flush events are applied mispredicts
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, active & ~en[3]};
    flush_events_d = flush_events_q + {31'd0, active & ~freeze & mispredict_E};
  end
  // performance counter registers, wrapping at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed bench with a behavioural hazard model checked every cycle
module tb_pipeline_hazard_controller;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic RegWriteE, mispredict_E, mem_req_M, mem_ready, halt_req;
  logic [1:0] ResultSrcE;
  logic en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, halted, mem_timeout;
  logic [31:0] stall_cycles, flush_events;
  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int m_mode, m_wait, m_adv;
  logic [31:0] m_sc, m_fc;
  pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .mispredict_E(mispredict_E), .mem_req_M(mem_req_M),
    .mem_ready(mem_ready), .halt_req(halt_req), .en_F(en_F), .en_D(en_D), .en_E(en_E),
    .en_M(en_M), .en_W(en_W), .flush_D(flush_D), .flush_E(flush_E), .halted(halted),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", n, cyc_n, a, e);
    end
  endtask
  task automatic model_reset();
    m_mode = 0;
    m_wait = 0;
    m_adv = 0;
    m_sc = 0;
    m_fc = 0;
  endtask
  task automatic check_and_step();
    string act;
    logic [6:0] ef;
    logic frz, lu;
    logic [31:0] esc, efc;
    frz = mem_req_M & ~mem_ready;
    lu = RegWriteE && ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (!rst) begin
      cmp("reset_ctl", {25'd0, en_F, en_D, en_E, en_M, en_W, flush_D, flush_E}, 32'd0);
      cmp("reset_sts", {30'd0, halted, mem_timeout}, 32'd0);
      cmp("reset_cnt", stall_cycles | flush_events, 32'd0);
      model_reset();
      return;
    end
`ifdef HAZARD_PERF_CNT_EN
    esc = m_sc;
    efc = m_fc;
`else
    esc = 0;
    efc = 0;
`endif
    cmp("halted", {31'd0, halted}, {31'd0, m_mode == 2});
    cmp("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_mode == 3});
    cmp("stall_cycles", stall_cycles, esc);
    cmp("flush_events", flush_events, efc);
    if (m_mode == 3) act = "dead";
    else if (m_mode == 2) act = "hold";
    else if (frz) act = "freeze";
    else if (mispredict_E) act = "redirect";
    else if (lu) act = "bubble";
    else act = (m_mode == 1) ? "drain" : "advance";
    case (act)
      "redirect": ef = 7'b1111111;
      "bubble":   ef = 7'b0011101;
      "hold":     ef = 7'b0011100;
      "drain":    ef = 7'b0111110;
      "advance":  ef = 7'b1111100;
      default:    ef = 7'b0000000;
    endcase
    cmp({"ctl_", act}, {25'd0, en_F, en_D, en_E, en_M, en_W, flush_D, flush_E}, {25'd0, ef});
    if (m_mode <= 1) begin
      m_wait = frz ? m_wait + 1 : 0;
      if (act == "freeze" || act == "bubble") m_sc++;
      if (act == "redirect") m_fc++;
      if (m_wait == 4) m_mode = 3;
      else if (m_mode == 0 && halt_req) begin
        m_mode = 1;
        m_adv = 0;
      end else if (m_mode == 1 && (act == "redirect" || act == "drain")) begin
        m_adv++;
        if (m_adv == 4) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      m_wait = 0;
      if (!halt_req) m_mode = 0;
    end
  endtask
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_and_step();
      @(posedge clk);
      #1;
      cyc_n++;
    end
  endtask
  task automatic clr();
    Rs1D = 0; Rs2D = 0; RdE = 0; RegWriteE = 0; ResultSrcE = 0;
    mispredict_E = 0; mem_req_M = 0; mem_ready = 0; halt_req = 0;
  endtask
  initial begin
    model_reset();
    clr();
    rst = 1'b0;
    #1;
    cmp("lit_reset_enF", {31'd0, en_F}, 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(2);
    cmp("lit_run_en", {27'd0, en_F, en_D, en_E, en_M, en_W}, 32'h1f);
    RegWriteE = 1; ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
    #1;
    cmp("lit_lu", {29'd0, en_F, en_D, flush_E}, 32'b001);
    cyc();
    RdE = 0;
    #1;
    cmp("lit_rd0_enD", {31'd0, en_D}, 32'd1);
    cyc();
    clr();
    cyc();
    mispredict_E = 1;
    #1;
    cmp("lit_mp", {25'd0, en_F, en_D, en_E, en_M, en_W, flush_D, flush_E}, 32'h7f);
    cyc();
    mispredict_E = 0;
    #1;
    cmp("lit_mp_off", {31'd0, flush_D}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    cmp("lit_sc1", stall_cycles, 32'd1);
    cmp("lit_fc1", flush_events, 32'd1);
`else
    cmp("lit_cnt0", stall_cycles | flush_events, 32'd0);
`endif
    cyc();
    mem_req_M = 1; mem_ready = 0;
    cyc(2);
    mispredict_E = 1;
    cyc();
    mem_ready = 1;
    #1;
    cmp("lit_frz_mp", {31'd0, flush_D}, 32'd1);
    cyc();
    clr();
    #1;
    cmp("lit_no_err", {30'd0, mem_timeout, en_F}, 32'd1);
    cyc();
    halt_req = 1;
    #1;
    cmp("lit_halt_run", {31'd0, en_F}, 32'd1);
    cyc();
    cmp("lit_drain", {30'd0, en_F, flush_D}, 32'b01);
    cyc(4);
    cmp("lit_halted", {29'd0, halted, en_D, en_E}, 32'b101);
    cyc();
    halt_req = 0;
    cyc();
    cmp("lit_resume", {30'd0, halted, en_F}, 32'b01);
    halt_req = 1;
    cyc();
    halt_req = 0;
    cyc();
    mispredict_E = 1;
    #1;
    cmp("lit_drain_mp", {30'd0, en_F, flush_D}, 32'b11);
    cyc();
    clr();
    RegWriteE = 1; ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    cyc();
    clr();
    cyc(2);
    cmp("lit_halted2", {31'd0, halted}, 32'd1);
    cyc();
    cmp("lit_unhalt2", {31'd0, halted}, 32'd0);
    halt_req = 1;
    cyc(3);
    rst = 1'b0;
    #1;
    cmp("lit_rst_drain", {23'd0, en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, halted, mem_timeout}, 32'd0);
    cyc(2);
    halt_req = 0;
    rst = 1'b1;
    #1;
    cmp("lit_post_rst", {31'd0, en_F}, 32'd1);
    cmp("lit_post_rst_cnt", stall_cycles | flush_events, 32'd0);
    cyc();
    mem_req_M = 1; mem_ready = 0;
    cyc(4);
    cmp("lit_timeout", {30'd0, mem_timeout, en_E}, 32'b10);
    clr();
    cyc(2);
    cmp("lit_sticky", {31'd0, mem_timeout}, 32'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
